// File: rtl/rx_slip_ctrl.sv
// rx_slip_ctrl
//   Turns one-cycle slip requests from the block-lock FSM into transceiver
//   RXSLIP pulses followed by a settle gap, and holds the lock FSM off while
//   the RX data is unstable. After MAX_SLIPS slips without lock, the next
//   request is escalated to a transceiver RX datapath reset instead.
//
// Ports:
//   i_clk               RX user clock
//   i_reset_n           asynchronous active-low reset
//   i_slip_req          slip request pulse from lock FSM
//   i_block_lock        block lock status
//   i_gt_rx_reset_done  transceiver RX reset complete (level)
//   o_gt_rxslip         RXSLIP to transceiver
//   o_gt_rx_reset       RX datapath reset request to transceiver
//   o_hold              lock FSM must not sample headers / must reset counters
//   o_busy              controller not idle
//   o_slip_count        slips since last lock or RX reset
//   o_lock_loss_count   saturating count of block_lock 1->0 edges
module rx_slip_ctrl #(
    parameter int SLIP_PULSE_CYCLES = 1,
    parameter int SLIP_WAIT_CYCLES  = 32,
    parameter int MAX_SLIPS         = 66,
    parameter int RX_RESET_CYCLES   = 16,
    parameter int CNT_W             = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_slip_req,
    input  logic             i_block_lock,
    input  logic             i_gt_rx_reset_done,
    output logic             o_gt_rxslip,
    output logic             o_gt_rx_reset,
    output logic             o_hold,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_slip_count,
    output logic [CNT_W-1:0] o_lock_loss_count
);

    localparam int MAX_A   = (SLIP_PULSE_CYCLES > SLIP_WAIT_CYCLES) ? SLIP_PULSE_CYCLES : SLIP_WAIT_CYCLES;
    localparam int MAX_CYC = (MAX_A > RX_RESET_CYCLES) ? MAX_A : RX_RESET_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SLIP_PULSE,
        SLIP_WAIT,
        RX_RESET,
        RESET_WAIT
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic               lock_q;
    logic [CNT_W-1:0]   slip_base;

    // A lock seen in the same IDLE cycle as a slip request clears the count
    // first, so the slip is counted from zero and never escalates.
    always_comb begin
        slip_base = i_block_lock ? '0 : o_slip_count;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state             <= IDLE;
            tmr               <= '0;
            lock_q            <= 1'b0;
            o_gt_rxslip       <= 1'b0;
            o_gt_rx_reset     <= 1'b0;
            o_hold            <= 1'b0;
            o_busy            <= 1'b0;
            o_slip_count      <= '0;
            o_lock_loss_count <= '0;
        end else begin
            lock_q <= i_block_lock;
            if (lock_q && !i_block_lock && (o_lock_loss_count != '1)) begin
                o_lock_loss_count <= o_lock_loss_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_slip_req && (slip_base < CNT_W'(MAX_SLIPS))) begin
                        state        <= SLIP_PULSE;
                        tmr          <= TMR_W'(SLIP_PULSE_CYCLES - 1);
                        o_slip_count <= slip_base + 1'b1;
                        o_gt_rxslip  <= 1'b1;
                        o_hold       <= 1'b1;
                        o_busy       <= 1'b1;
                    end else if (i_slip_req) begin
                        state         <= RX_RESET;
                        tmr           <= TMR_W'(RX_RESET_CYCLES - 1);
                        o_gt_rx_reset <= 1'b1;
                        o_hold        <= 1'b1;
                        o_busy        <= 1'b1;
                    end else if (i_block_lock) begin
                        o_slip_count <= '0;
                    end
                end
                SLIP_PULSE: begin
                    if (tmr == '0) begin
                        state       <= SLIP_WAIT;
                        tmr         <= TMR_W'(SLIP_WAIT_CYCLES - 1);
                        o_gt_rxslip <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                SLIP_WAIT: begin
                    if (tmr == '0) begin
                        state  <= IDLE;
                        o_hold <= 1'b0;
                        o_busy <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                RX_RESET: begin
                    if (tmr == '0) begin
                        state         <= RESET_WAIT;
                        o_gt_rx_reset <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                RESET_WAIT: begin
                    if (i_gt_rx_reset_done) begin
                        state        <= IDLE;
                        o_slip_count <= '0;
                        o_hold       <= 1'b0;
                        o_busy       <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    o_gt_rxslip   <= 1'b0;
                    o_gt_rx_reset <= 1'b0;
                    o_hold        <= 1'b0;
                    o_busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
